// File: rtl/burst_ramp_gain.sv
// ---------------------------------------------------------------------------
// burst_ramp_gain
//
// Output stage between the I/Q modulator and the DAC sample port. Each sample
// goes through two stages:
//   stage 1: programmable Q1.15 digital gain with saturation to 16 bits.
//   stage 2: a linear amplitude envelope for burst on/off shaping. The
//            envelope runs 0..ENV_MAX (ENV_MAX = 2^RAMP_SHIFT) and is applied
//            as (s1 * env) >>> RAMP_SHIFT.
// The block takes one sample per clock. din/gain reach dout two edges later.
//
// Parameters
//   RAMP_SHIFT : ramp length is 2^RAMP_SHIFT samples (legal range 1..12)
//
// Ports
//   clk     in   sample clock, rising edge
//   rst     in   synchronous active-high reset
//   en      in   burst enable (1 = ramp up / hold, 0 = ramp down / idle)
//   din     in   signed 16-bit modulated sample
//   gain    in   unsigned Q1.15 gain (32768 = unity)
//   sat_clr in   clears the sticky saturation flag
//   dout    out  signed 16-bit gated and scaled sample
//   active  out  1 whenever the envelope FSM is not IDLE
//   state   out  FSM state: IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3
//   sat     out  sticky flag: stage 1 saturated since the last clear
// ---------------------------------------------------------------------------
module burst_ramp_gain #(
    parameter int RAMP_SHIFT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [15:0] din,
    input  logic        [15:0] gain,
    input  logic               sat_clr,
    output logic signed [15:0] dout,
    output logic               active,
    output logic        [1:0]  state,
    output logic               sat
);

    // Envelope counter width: must hold ENV_MAX itself, so one bit more
    // than RAMP_SHIFT.
    localparam int EW = RAMP_SHIFT + 1;
    // Stage-2 product width. |s1| <= 2^15 and e1 <= 2^RAMP_SHIFT, so the
    // product needs RAMP_SHIFT+16 magnitude bits plus a sign bit.
    localparam int PW = RAMP_SHIFT + 17;

    localparam logic [EW-1:0] ENV_ZERO = {EW{1'b0}};
    localparam logic [EW-1:0] ENV_ONE  = {{RAMP_SHIFT{1'b0}}, 1'b1};
    localparam logic [EW-1:0] ENV_MAX  = {1'b1, {RAMP_SHIFT{1'b0}}};
    localparam logic [EW-1:0] ENV_TOP  = ENV_MAX - ENV_ONE;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    // Q1.15 rescale and saturate a 33-bit gain product.
    // The return value is {saturated, value[15:0]}. The arithmetic shift
    // floors toward minus infinity.
    function automatic logic [16:0] sat_q15(input logic signed [32:0] prod);
        logic signed [32:0] q;
        q = prod >>> 15;
        if (q > 33'sd32767) begin
            return {1'b1, 16'h7FFF};
        end else if (q < -33'sd32768) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, 16'(q)};
        end
    endfunction

    // Floor-scale the envelope product back to 16 bits. It cannot overflow
    // because e1 never exceeds ENV_MAX.
    function automatic logic [15:0] env_scale(input logic signed [PW-1:0] prod);
        return 16'(prod >>> RAMP_SHIFT);
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [EW-1:0]    env_r;
    logic [EW-1:0]    env_s;
    logic [EW-1:0]    env_inc_s;
    logic [EW-1:0]    env_dec_s;

    logic signed [32:0]   din_x_s;
    logic signed [32:0]   gain_x_s;
    logic signed [32:0]   p1_s;
    logic        [16:0]   s1_sat_s;
    logic signed [15:0]   s1_r;
    logic        [EW-1:0] e1_r;

    logic signed [PW-1:0] s1_x_s;
    logic signed [PW-1:0] e1_x_s;
    logic signed [PW-1:0] p2_s;
    logic signed [15:0]   dout_s;

    assign env_inc_s = env_r + ENV_ONE;
    assign env_dec_s = env_r - ENV_ONE;

    // Envelope FSM next-state logic. A reversal mid-ramp continues from the
    // current env, so the ramp never restarts.
    always_comb begin
        state_s = state_r;
        env_s   = env_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_s = RAMP_UP;
                    env_s   = ENV_ONE;
                end else begin
                    state_s = IDLE;
                    env_s   = ENV_ZERO;
                end
            end
            RAMP_UP: begin
                if (en) begin
                    env_s   = env_inc_s;
                    state_s = (env_inc_s == ENV_MAX) ? ON : RAMP_UP;
                end else begin
                    env_s   = env_dec_s;
                    state_s = (env_dec_s == ENV_ZERO) ? IDLE : RAMP_DOWN;
                end
            end
            ON: begin
                if (en) begin
                    state_s = ON;
                    env_s   = ENV_MAX;
                end else begin
                    state_s = RAMP_DOWN;
                    env_s   = ENV_TOP;
                end
            end
            RAMP_DOWN: begin
                if (en) begin
                    env_s   = env_inc_s;
                    state_s = (env_inc_s == ENV_MAX) ? ON : RAMP_UP;
                end else begin
                    env_s   = env_dec_s;
                    state_s = (env_dec_s == ENV_ZERO) ? IDLE : RAMP_DOWN;
                end
            end
            default: begin
                state_s = IDLE;
                env_s   = ENV_ZERO;
            end
        endcase
    end

    // FSM state, envelope and active registers. active is decoded from the
    // next state so that it changes on the same edge as state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            env_r   <= ENV_ZERO;
            active  <= 1'b0;
        end else begin
            state_r <= state_s;
            env_r   <= env_s;
            active  <= (state_s != IDLE);
        end
    end

    assign state = state_r;

    // Stage-1 gain multiply. gain is zero-extended, so it is always
    // non-negative. 33 bits hold the full product exactly.
    always_comb begin
        din_x_s  = {{17{din[15]}}, din};
        gain_x_s = {17'd0, gain};
        p1_s     = din_x_s * gain_x_s;
        s1_sat_s = sat_q15(p1_s);
    end

    // Stage-2 envelope multiply on the registered stage-1 sample.
    always_comb begin
        s1_x_s = {{(PW-16){s1_r[15]}}, s1_r};
        e1_x_s = {{(PW-EW){1'b0}}, e1_r};
        p2_s   = s1_x_s * e1_x_s;
        dout_s = env_scale(p2_s);
    end

    // Pipeline registers. e1 captures env before this edge's update, which
    // lines it up with the sample captured on the same edge. sat set wins
    // over sat_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 16'sd0;
            e1_r <= ENV_ZERO;
            dout <= 16'sd0;
            sat  <= 1'b0;
        end else begin
            s1_r <= s1_sat_s[15:0];
            e1_r <= env_r;
            dout <= dout_s;
            if (s1_sat_s[16]) begin
                sat <= 1'b1;
            end else if (sat_clr) begin
                sat <= 1'b0;
            end else begin
                sat <= sat;
            end
        end
    end

endmodule

// File: doc/burst_ramp_gain.md
# burst_ramp_gain

Output stage placed directly downstream of the I/Q modulator in the baseband-generator top, before the DAC sample port. It applies a programmable digital gain with saturation to the modulated sample stream. It then gates the stream with a linear amplitude ramp (burst on/off shaping), so bursts start and stop without spectral splatter. It runs at full sample rate, one sample per clock.

## Interface
- RAMP_SHIFT, 8: ramp length is ENV_MAX = 2^RAMP_SHIFT samples; legal range 1..12.
- clk  in  1  sample clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  burst enable, level-sensitive; 1 = ramp toward full amplitude, 0 = ramp toward zero.
- din  in  16  signed modulated sample, one per clock.
- gain  in  16  unsigned Q1.15 gain; 32768 = unity, 65535 ≈ 2.0; sampled every clock.
- sat_clr  in  1  clears the sticky saturation flag.
- dout  out  16  signed gated/scaled sample to DAC.
- active  out  1  1 whenever state ≠ IDLE.
- state  out  2  IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3.
- sat  out  1  sticky: a stage-1 saturation occurred since the last clear.

## Operation
- Envelope counter env: unsigned, RAMP_SHIFT+1 bits, range 0..ENV_MAX. It changes by at most ±1 per clock.
- FSM, evaluated on each edge:
  - IDLE (env=0): if en=1, go to RAMP_UP with env←1; otherwise stay.
  - RAMP_UP: if en=1, env←env+1, and go to ON when the new env = ENV_MAX. If en=0, env←env−1 and go to RAMP_DOWN, or to IDLE if the new env = 0.
  - ON (env=ENV_MAX): if en=0, env←ENV_MAX−1 and go to RAMP_DOWN; otherwise stay.
  - RAMP_DOWN: if en=0, env←env−1, and go to IDLE when the new env = 0. If en=1, env←env+1 and go to RAMP_UP, or to ON if the new env = ENV_MAX.
- Corner cases:
  - With RAMP_SHIFT=1, ENV_MAX=2 and every rule above still holds.
  - Reversal mid-ramp continues from the current env. The ramp does not restart.
- Stage 1 (gain):
  - p1 = din × {1'b0,gain}, a 33-bit signed product.
  - s1 = p1 >>> 15 (arithmetic shift, floor).
  - s1 saturates to +32767 / −32768.
  - Saturation sets sat in the same edge that registers s1.
- Stage 2 (envelope): dout = (s1 × e1) >>> RAMP_SHIFT, floor. Because e1 ≤ ENV_MAX, the result cannot overflow.
- Sticky flag sat: set has priority over sat_clr in the same cycle; rst clears it.
- Reset mid-burst: the next edge forces IDLE, env=0, all pipeline registers 0, dout=0, active=0, sat=0. There is no ramp-down on reset.

## Timing
- Latency: din(t) and gain(t) appear in dout at t+2 edges.
- Edge t registers s1 ← sat(din×gain>>>15) and e1 ← env, where env is the value before the edge-t update. Edge t+1 registers dout.
- state and active are registered FSM outputs; they update on the same edge as env.
- In the first edge with en=1 in IDLE, the sample captured uses env=0. The first nonzero dout therefore appears at the 3rd edge after en was sampled high.
- Full ramp: ENV_MAX edges from IDLE to ON, and ENV_MAX edges from ON to IDLE.
- gain is not retimed. A change takes effect on the next sample, with the same 2-cycle latency.

## Test plan
- Reset: rst=1 for 3 clocks with random din/en, then rst=0 and en=0. Required: dout=0, active=0, state=0, sat=0 held indefinitely.
- Ramp up (RAMP_SHIFT=4, din=16384, gain=32768), assert en:
  - dout steps 0, 1024, 2048, … 16384 in increments of 1024, one per clock.
  - state=ON exactly 16 edges after en is sampled high.
  - dout holds at 16384 thereafter.
- Ramp down (from the ON state above, deassert en):
  - dout steps 15360, 14336, … 0.
  - state goes 3 → 0 after 16 edges; active drops on the same edge.
- Reversal: en=1 for 5 edges (env=5), then en=0 for 3 edges (env=2), then en=1.
  - env sequence is 1,2,3,4,5,4,3,2,3,4,….
  - state goes 1→3→1, with no jump to IDLE or ON.
- Saturation:
  - gain=65535, din=32767: dout at ON = 32767 and sat=1.
  - din=−32768: dout = −32768.
  - sat_clr pulse: sat=0 afterwards. If saturation recurs in the same cycle as the clear, sat stays 1.
- Sign/rounding (RAMP_SHIFT=4, gain=32768):
  - din=−1 at ON: dout = −1 (floor).
  - din=−16384 at env=8: dout = −8192.
  - Reset asserted at env=8 mid-ramp: dout=0 two edges later and state=IDLE.
